// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register for the 8-bit MIPS pipeline: valid/stall/flush control,
// forwarding-hit detection against two ID/EX sources and a saturating bubble counter.

module ex_mem_pipe_reg_chk #(
  parameter int DATA_W   = 8,
  parameter int INSTR_W  = 19,
  parameter int MUX_W    = 2,
  parameter int REG_W    = 3,
  parameter int DEST_LSB = 8
) ();
  // Elaboration-time parameter sanity checks.
  generate
    if (DATA_W < 1) begin : g_bad_data_w
      $fatal(1, "ex_mem_pipe_reg: DATA_W must be >= 1");
    end
    if (MUX_W < 1) begin : g_bad_mux_w
      $fatal(1, "ex_mem_pipe_reg: MUX_W must be >= 1");
    end
    if (DEST_LSB + REG_W > INSTR_W) begin : g_bad_dest
      $fatal(1, "ex_mem_pipe_reg: destination field exceeds instruction width");
    end
  endgenerate
endmodule

module ex_mem_pipe_reg #(
  parameter int DATA_W   = 8,
  parameter int INSTR_W  = 19,
  parameter int MUX_W    = 2,
  parameter int REG_W    = 3,
  parameter int DEST_LSB = 8,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [DATA_W-1:0]  ID_EX_B,
  input  logic [DATA_W-1:0]  shift_out,
  input  logic [INSTR_W-1:0] ID_EX_instruction,
  input  logic               ID_EX_mem_write,
  input  logic               ID_EX_reg_write,
  input  logic [MUX_W-1:0]   ID_EX_reg_write_mux,
  input  logic [REG_W-1:0]   src_a,
  input  logic [REG_W-1:0]   src_b,
  input  logic               cnt_clear,
  output logic [DATA_W-1:0]  EX_MEM_alu_out,
  output logic [DATA_W-1:0]  EX_MEM_B,
  output logic [DATA_W-1:0]  EX_MEM_shift_out,
  output logic [INSTR_W-1:0] EX_MEM_instruction,
  output logic               EX_MEM_mem_write,
  output logic               EX_MEM_reg_write,
  output logic [MUX_W-1:0]   EX_MEM_reg_write_mux,
  output logic               EX_MEM_valid,
  output logic               fwd_a_hit,
  output logic               fwd_b_hit,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ex_mem_pipe_reg_chk #(
    .DATA_W   (DATA_W),
    .INSTR_W  (INSTR_W),
    .MUX_W    (MUX_W),
    .REG_W    (REG_W),
    .DEST_LSB (DEST_LSB)
  ) u_chk ();

  logic [DATA_W-1:0]  alu_r;
  logic [DATA_W-1:0]  b_r;
  logic [DATA_W-1:0]  shift_r;
  logic [INSTR_W-1:0] instr_r;
  logic               mem_write_r;
  logic               reg_write_r;
  logic [MUX_W-1:0]   mux_r;
  logic               valid_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               bubble_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [REG_W-1:0]   dest_s;

  // Bubble detection and saturating counter next-state; clear beats increment.
  always_comb begin
    bubble_s   = flush | (~stall & ~in_valid);
    cnt_next_s = cnt_r;
    if (cnt_clear) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (bubble_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Pipeline register: reset > flush > stall > load. Flush only kills the
  // valid/write controls; payload fields keep their old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_r       <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      instr_r     <= {INSTR_W{1'b0}};
      mem_write_r <= 1'b0;
      reg_write_r <= 1'b0;
      mux_r       <= {MUX_W{1'b0}};
      valid_r     <= 1'b0;
    end else if (flush) begin
      valid_r     <= 1'b0;
      mem_write_r <= 1'b0;
      reg_write_r <= 1'b0;
    end else if (stall) begin
      valid_r     <= valid_r;
    end else begin
      alu_r       <= alu_out;
      b_r         <= ID_EX_B;
      shift_r     <= shift_out;
      instr_r     <= ID_EX_instruction;
      mem_write_r <= ID_EX_mem_write & in_valid;
      reg_write_r <= ID_EX_reg_write & in_valid;
      mux_r       <= ID_EX_reg_write_mux;
      valid_r     <= in_valid;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  // Forward requests look only at registered state, never at same-cycle EX inputs.
  always_comb begin
    dest_s    = instr_r[DEST_LSB +: REG_W];
    fwd_a_hit = valid_r & reg_write_r & (dest_s != {REG_W{1'b0}}) & (dest_s == src_a);
    fwd_b_hit = valid_r & reg_write_r & (dest_s != {REG_W{1'b0}}) & (dest_s == src_b);
  end

  assign EX_MEM_alu_out       = alu_r;
  assign EX_MEM_B             = b_r;
  assign EX_MEM_shift_out     = shift_r;
  assign EX_MEM_instruction   = instr_r;
  assign EX_MEM_mem_write     = mem_write_r;
  assign EX_MEM_reg_write     = reg_write_r;
  assign EX_MEM_reg_write_mux = mux_r;
  assign EX_MEM_valid         = valid_r;
  assign bubble_cnt           = cnt_r;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed plan steps followed by random
// traffic, all compared against a behavioural model of the register's contents.
`timescale 1ns/1ps

module tb_ex_mem_pipe_reg;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [7:0]  alu_out, ID_EX_B, shift_out;
  logic [18:0] ID_EX_instruction;
  logic        ID_EX_mem_write, ID_EX_reg_write;
  logic [1:0]  ID_EX_reg_write_mux;
  logic [2:0]  src_a, src_b;
  logic        cnt_clear;
  logic [7:0]  EX_MEM_alu_out, EX_MEM_B, EX_MEM_shift_out;
  logic [18:0] EX_MEM_instruction;
  logic        EX_MEM_mem_write, EX_MEM_reg_write;
  logic [1:0]  EX_MEM_reg_write_mux;
  logic        EX_MEM_valid, fwd_a_hit, fwd_b_hit;
  logic [CNT_W-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Model of what the EX/MEM register should hold
  logic        m_valid, m_mw, m_rw;
  logic [7:0]  m_alu, m_b, m_sh;
  logic [18:0] m_instr;
  logic [1:0]  m_mux;
  int          m_cnt;

  ex_mem_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_out(alu_out), .ID_EX_B(ID_EX_B), .shift_out(shift_out),
    .ID_EX_instruction(ID_EX_instruction), .ID_EX_mem_write(ID_EX_mem_write),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_reg_write_mux(ID_EX_reg_write_mux),
    .src_a(src_a), .src_b(src_b), .cnt_clear(cnt_clear),
    .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_B(EX_MEM_B), .EX_MEM_shift_out(EX_MEM_shift_out),
    .EX_MEM_instruction(EX_MEM_instruction), .EX_MEM_mem_write(EX_MEM_mem_write),
    .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_reg_write_mux(EX_MEM_reg_write_mux),
    .EX_MEM_valid(EX_MEM_valid), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the specified edge behaviour to the model using the inputs about to be sampled.
  task automatic model_edge();
    bit bubble;
    if (reset) begin
      {m_valid, m_mw, m_rw} = 3'b000;
      m_alu = 8'h00; m_b = 8'h00; m_sh = 8'h00; m_instr = 19'h0; m_mux = 2'b00;
      m_cnt = 0;
    end else begin
      bubble = flush || (!stall && !in_valid);
      if (flush) begin
        m_valid = 1'b0; m_mw = 1'b0; m_rw = 1'b0;
      end else if (!stall) begin
        m_alu = alu_out; m_b = ID_EX_B; m_sh = shift_out;
        m_instr = ID_EX_instruction; m_mux = ID_EX_reg_write_mux;
        m_valid = in_valid;
        m_mw = ID_EX_mem_write && in_valid;
        m_rw = ID_EX_reg_write && in_valid;
      end
      if (cnt_clear) m_cnt = 0;
      else if (bubble && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
    end
  endtask

  function automatic logic fwd_expect(input logic [2:0] src);
    int dest;
    dest = (m_instr >> 8) % 8;
    return m_valid && m_rw && (dest != 0) && (dest == src);
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(EX_MEM_valid), 32'(m_valid));
    chk({tag, ".alu"},   32'(EX_MEM_alu_out), 32'(m_alu));
    chk({tag, ".b"},     32'(EX_MEM_B), 32'(m_b));
    chk({tag, ".sh"},    32'(EX_MEM_shift_out), 32'(m_sh));
    chk({tag, ".instr"}, 32'(EX_MEM_instruction), 32'(m_instr));
    chk({tag, ".mw"},    32'(EX_MEM_mem_write), 32'(m_mw));
    chk({tag, ".rw"},    32'(EX_MEM_reg_write), 32'(m_rw));
    chk({tag, ".mux"},   32'(EX_MEM_reg_write_mux), 32'(m_mux));
    chk({tag, ".cnt"},   32'(bubble_cnt), 32'(m_cnt));
    chk({tag, ".fwda"},  32'(fwd_a_hit), 32'(fwd_expect(src_a)));
    chk({tag, ".fwdb"},  32'(fwd_b_hit), 32'(fwd_expect(src_b)));
  endtask

  task automatic set_ex(input logic v, input logic [7:0] a, input logic [18:0] ins,
                        input logic mw, input logic rw);
    in_valid = v; alu_out = a; ID_EX_instruction = ins;
    ID_EX_mem_write = mw; ID_EX_reg_write = rw;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
    alu_out = 8'h00; ID_EX_B = 8'h00; shift_out = 8'h00; ID_EX_instruction = 19'h0;
    ID_EX_mem_write = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_reg_write_mux = 2'b00;
    src_a = 3'd0; src_b = 3'd0;
    m_cnt = 0;

    // Reset then load
    tick(); tick();
    check_all("reset");
    chk("reset_valid", 32'(EX_MEM_valid), 32'd0);
    reset = 1'b0;
    set_ex(1'b1, 8'h5A, 19'h12345, 1'b1, 1'b1);
    ID_EX_B = 8'h3C; shift_out = 8'hF0; ID_EX_reg_write_mux = 2'b10;
    tick();
    check_all("load");
    chk("load_alu", 32'(EX_MEM_alu_out), 32'h5A);
    chk("load_b", 32'(EX_MEM_B), 32'h3C);
    chk("load_sh", 32'(EX_MEM_shift_out), 32'hF0);
    chk("load_instr", 32'(EX_MEM_instruction), 32'h12345);
    chk("load_ctl", 32'({EX_MEM_valid, EX_MEM_mem_write, EX_MEM_reg_write, EX_MEM_reg_write_mux}), 32'b11110);
    chk("load_cnt", 32'(bubble_cnt), 32'd0);

    // Stall hold
    alu_out = 8'h11;
    tick();
    stall = 1'b1; alu_out = 8'h22;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall");
      chk("stall_alu", 32'(EX_MEM_alu_out), 32'h11);
    end
    stall = 1'b0;
    tick();
    chk("stall_release", 32'(EX_MEM_alu_out), 32'h22);

    // Flush overrides a simultaneous stall
    flush = 1'b1; stall = 1'b1; alu_out = 8'h77;
    tick();
    check_all("flush");
    chk("flush_ctl", 32'({EX_MEM_valid, EX_MEM_mem_write, EX_MEM_reg_write}), 32'd0);
    chk("flush_alu", 32'(EX_MEM_alu_out), 32'h22);
    chk("flush_cnt", 32'(bubble_cnt), 32'd1);

    // Invalid entries never write
    flush = 1'b0; stall = 1'b0;
    set_ex(1'b0, 8'h33, 19'h00700, 1'b1, 1'b1);
    tick();
    check_all("invalid");
    chk("invalid_writes", 32'({EX_MEM_mem_write, EX_MEM_reg_write}), 32'd0);
    chk("invalid_cnt", 32'(bubble_cnt), 32'd2);

    // Forwarding
    set_ex(1'b1, 8'h44, 19'h00300, 1'b0, 1'b1);
    tick();
    src_a = 3'd3; src_b = 3'd4; #1;
    check_all("fwd_dest3");
    chk("fwd_a_hit3", 32'(fwd_a_hit), 32'd1);
    chk("fwd_b_miss4", 32'(fwd_b_hit), 32'd0);
    set_ex(1'b1, 8'h45, 19'h00000, 1'b0, 1'b1);
    tick();
    src_a = 3'd0; #1;
    chk("fwd_r0", 32'(fwd_a_hit), 32'd0);
    set_ex(1'b1, 8'h46, 19'h00300, 1'b0, 1'b0);
    tick();
    src_a = 3'd3; #1;
    chk("fwd_norw", 32'(fwd_a_hit), 32'd0);
    check_all("fwd_norw");

    // Counter saturation and clear
    cnt_clear = 1'b1;
    tick();
    chk("cnt_cleared", 32'(bubble_cnt), 32'd0);
    cnt_clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_all("sat");
    chk("cnt_sat", 32'(bubble_cnt), 32'hF);
    cnt_clear = 1'b1; flush = 1'b1;
    tick();
    chk("cnt_clear_bubble", 32'(bubble_cnt), 32'd0);
    cnt_clear = 1'b0; flush = 1'b0;

    // Reset mid-stall clears on that edge
    set_ex(1'b1, 8'h99, 19'h00500, 1'b1, 1'b1);
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    check_all("rst_stall");
    chk("rst_stall_valid", 32'(EX_MEM_valid), 32'd0);
    reset = 1'b0; stall = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      cnt_clear = !stall && ($urandom_range(0, 31) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      alu_out = 8'($urandom); ID_EX_B = 8'($urandom); shift_out = 8'($urandom);
      ID_EX_instruction = 19'($urandom);
      ID_EX_mem_write = 1'($urandom); ID_EX_reg_write = 1'($urandom);
      ID_EX_reg_write_mux = 2'($urandom);
      tick();
      src_a = 3'($urandom); src_b = 3'($urandom); #1;
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
